// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, per-opcode
// control decode and immediate generation.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int RIDX_W = $clog2(NREGS);

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic     legal;
        logic     use_rs1;
        logic     use_rs2;
        logic     has_rd;
        logic     is_r;
        imm_fmt_e imm_fmt;
    } dec_ctrl_t;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN-1:0]   rs1_value;
        logic [XLEN-1:0]   rs2_value;
        logic [XLEN-1:0]   imm_value;
        logic [XLEN-1:0]   pc;
        logic [RIDX_W-1:0] rd;
        logic              illegal;
    } bundle_t;

    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode);
        dec_ctrl_t c;
        c = '{legal: 1'b1, use_rs1: 1'b0, use_rs2: 1'b0, has_rd: 1'b0,
              is_r: 1'b0, imm_fmt: IMM_NONE};
        case (opcode)
            R_TYPE: begin
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
                c.has_rd  = 1'b1;
                c.is_r    = 1'b1;
            end
            I_OP, LOAD, JALR: begin
                c.use_rs1 = 1'b1;
                c.has_rd  = 1'b1;
                c.imm_fmt = IMM_I;
            end
            STORE: begin
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
                c.imm_fmt = IMM_S;
            end
            BRANCH: begin
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
                c.imm_fmt = IMM_B;
            end
            LUI, AUIPC: begin
                c.has_rd  = 1'b1;
                c.imm_fmt = IMM_U;
            end
            JAL: begin
                c.has_rd  = 1'b1;
                c.imm_fmt = IMM_J;
            end
            // FENCE/ECALL/EBREAK are base-set but touch no registers here.
            FENCE, SYSTEM: c.imm_fmt = IMM_I;
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] ins,
                                                 input imm_fmt_e    fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, writeback and execute-side signals of the decode stage, bundled with
// the decode stage as slave and its environment as master.
interface decode_stage_if;
    import rv32i_pkg::*;

    logic              instr_valid_in;
    logic              instr_ready_out;
    logic [31:0]       instr_in;
    logic [XLEN-1:0]   pc_in;
    logic              flush_in;
    logic              wb_en_in;
    logic [RIDX_W-1:0] wb_rd_in;
    logic [XLEN-1:0]   wb_data_in;
    logic              valid_out;
    logic              ready_in;
    logic [6:0]        opcode_out;
    logic [2:0]        funct3_out;
    logic [6:0]        funct7_out;
    logic [XLEN-1:0]   rs1_value_out;
    logic [XLEN-1:0]   rs2_value_out;
    logic [XLEN-1:0]   imm_value_out;
    logic [XLEN-1:0]   pc_co_out;
    logic [RIDX_W-1:0] rd_out;
    logic              illegal_out;

    modport slave (
        input  instr_valid_in, instr_in, pc_in, flush_in,
               wb_en_in, wb_rd_in, wb_data_in, ready_in,
        output instr_ready_out, valid_out, opcode_out, funct3_out, funct7_out,
               rs1_value_out, rs2_value_out, imm_value_out, pc_co_out,
               rd_out, illegal_out
    );

    modport master (
        output instr_valid_in, instr_in, pc_in, flush_in,
               wb_en_in, wb_rd_in, wb_data_in, ready_in,
        input  instr_ready_out, valid_out, opcode_out, funct3_out, funct7_out,
               rs1_value_out, rs2_value_out, imm_value_out, pc_co_out,
               rd_out, illegal_out
    );

endinterface

// File: rtl/reg_file.sv
// Two-read, one-write register file; x0 reads as zero and a same-cycle write
// is forwarded straight to the read ports.
module reg_file #(
    parameter  int NUM_REGS = 32,
    parameter  int WIDTH    = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];

    // NOTE: the storage array is deliberately not reset; software initialises
    // architectural registers, and a reset here would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0)               ? '0    :
                    (we && waddr == raddr1)      ? wdata : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0)               ? '0    :
                    (we && waddr == raddr2)      ? wdata : regs_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register read with writeback forwarding, scoreboard
// hazard stall, and a registered operand bundle towards execute.
module decode_stage
    import rv32i_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  io
);

    logic [RIDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
    dec_ctrl_t         ctrl;
    logic              writes_rd;
    logic              hazard;
    logic              instr_ready;
    logic              accept;
    logic [XLEN-1:0]   rf_rs1, rf_rs2;
    logic [NREGS-1:0]  wb_mask, eff_pending, set_mask, clr_mask;
    logic [NREGS-1:0]  pending_d, pending_q;
    logic              valid_d, valid_q;
    bundle_t           bundle_new, bundle_d, bundle_q;

    assign rs1_idx   = io.instr_in[19:15];
    assign rs2_idx   = io.instr_in[24:20];
    assign rd_idx    = io.instr_in[11:7];
    assign ctrl      = decode_ctrl(io.instr_in[6:0]);
    assign writes_rd = ctrl.has_rd && (rd_idx != '0);

    reg_file #(
        .NUM_REGS (NREGS),
        .WIDTH    (XLEN)
    ) u_reg_file (
        .clk    (clk),
        .raddr1 (rs1_idx),
        .raddr2 (rs2_idx),
        .rdata1 (rf_rs1),
        .rdata2 (rf_rs2),
        .we     (io.wb_en_in),
        .waddr  (io.wb_rd_in),
        .wdata  (io.wb_data_in)
    );

    // A register being written back this cycle is no longer a hazard: the
    // reg file forwards the data in the same cycle.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see the
        // values just computed; clocked blocks use '<=' only.
        wb_mask = '0;
        if (io.wb_en_in) begin
            wb_mask[io.wb_rd_in] = 1'b1;
        end
        eff_pending = pending_q & ~wb_mask;
        hazard = (ctrl.use_rs1 && eff_pending[rs1_idx]) ||
                 (ctrl.use_rs2 && eff_pending[rs2_idx]) ||
                 (writes_rd    && eff_pending[rd_idx]);
    end

    assign instr_ready = (!valid_q || io.ready_in) && !hazard && !io.flush_in;
    assign accept      = io.instr_valid_in && instr_ready;

    assign bundle_new = '{
        opcode:    io.instr_in[6:0],
        funct3:    io.instr_in[14:12],
        funct7:    ctrl.is_r    ? io.instr_in[31:25] : 7'd0,
        rs1_value: ctrl.use_rs1 ? rf_rs1 : '0,
        rs2_value: ctrl.use_rs2 ? rf_rs2 : '0,
        imm_value: imm_gen(io.instr_in[31:7], ctrl.imm_fmt),
        pc:        io.pc_in,
        rd:        writes_rd ? rd_idx : '0,
        illegal:   !ctrl.legal
    };

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a value unassigned and no latch is inferred.
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (io.flush_in) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = bundle_new;
        end else if (valid_q && io.ready_in) begin
            valid_d = 1'b0;
        end
    end

    // Set beats clear on the same bit; a flushed bundle releases its own rd.
    always_comb begin
        set_mask = '0;
        if (accept && writes_rd) begin
            set_mask[rd_idx] = 1'b1;
        end
        clr_mask = wb_mask;
        if (io.flush_in && valid_q && bundle_q.rd != '0) begin
            clr_mask[bundle_q.rd] = 1'b1;
        end
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            bundle_q  <= '0;
            pending_q <= '0;
        end else begin
            valid_q   <= valid_d;
            bundle_q  <= bundle_d;
            pending_q <= pending_d;
        end
    end

    assign io.instr_ready_out = instr_ready;
    assign io.valid_out       = valid_q;
    assign io.opcode_out      = bundle_q.opcode;
    assign io.funct3_out      = bundle_q.funct3;
    assign io.funct7_out      = bundle_q.funct7;
    assign io.rs1_value_out   = bundle_q.rs1_value;
    assign io.rs2_value_out   = bundle_q.rs2_value;
    assign io.imm_value_out   = bundle_q.imm_value;
    assign io.pc_co_out       = bundle_q.pc;
    assign io.rd_out          = bundle_q.rd;
    assign io.illegal_out     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, forwarding, RAW stall, backpressure,
// flush, immediates and mid-operation reset.
module tb_decode_stage;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        bus.instr_valid_in = 1'b1;
        bus.instr_in       = instr;
        bus.pc_in          = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.wb_en_in   = en;
        bus.wb_rd_in   = rd;
        bus.wb_data_in = data;
    endtask

    initial begin
        reset              = 1'b1;
        bus.instr_valid_in = 1'b0;
        bus.instr_in       = 32'h0;
        bus.pc_in          = 32'h0;
        bus.flush_in       = 1'b0;
        bus.ready_in       = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset / idle
        check("rst_valid",   32'(bus.valid_out),       32'h0);
        check("rst_ready",   32'(bus.instr_ready_out), 32'h1);
        check("rst_pending", dut.pending_q,            32'h0);
        check("rst_rd",      32'(bus.rd_out),          32'h0);
        check("rst_imm",     bus.imm_value_out,        32'h0);
        check("rst_pc",      bus.pc_co_out,            32'h0);
        check("rst_illegal", 32'(bus.illegal_out),     32'h0);

        // Preload x1, x2, x5 through writeback
        wb(1'b1, 5'd1, 32'h0000_1000);
        tick();
        wb(1'b1, 5'd2, 32'h0000_CAFE);
        tick();
        wb(1'b1, 5'd5, 32'h0000_0010);
        tick();
        wb(1'b0, 5'd0, 32'h0);

        // addi x6,x5,-1
        bus.ready_in = 1'b1;
        issue(32'hFFF2_8313, 32'h100);
        #1 check("addi_ready", 32'(bus.instr_ready_out), 32'h1);
        tick();
        check("addi_valid",   32'(bus.valid_out),  32'h1);
        check("addi_rs1",     bus.rs1_value_out,   32'h0000_0010);
        check("addi_rs2",     bus.rs2_value_out,   32'h0);
        check("addi_imm",     bus.imm_value_out,   32'hFFFF_FFFF);
        check("addi_rd",      32'(bus.rd_out),     32'd6);
        check("addi_funct7",  32'(bus.funct7_out), 32'h0);
        check("addi_opcode",  32'(bus.opcode_out), 32'h13);
        check("addi_pc",      bus.pc_co_out,       32'h100);
        check("addi_pending", dut.pending_q,       32'h0000_0040);

        // add x7,x6,x6 stalls on x6
        issue(32'h0063_03B3, 32'h104);
        #1 check("raw_ready", 32'(bus.instr_ready_out), 32'h0);
        tick();
        check("raw_drain_valid", 32'(bus.valid_out),       32'h0);
        check("raw_still_stall", 32'(bus.instr_ready_out), 32'h0);
        wb(1'b1, 5'd6, 32'h0000_000F);
        #1 check("raw_wb_ready", 32'(bus.instr_ready_out), 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("raw_valid",   32'(bus.valid_out), 32'h1);
        check("raw_rs1",     bus.rs1_value_out,  32'h0000_000F);
        check("raw_rs2",     bus.rs2_value_out,  32'h0000_000F);
        check("raw_rd",      32'(bus.rd_out),    32'd7);
        check("raw_imm",     bus.imm_value_out,  32'h0);
        check("raw_pending", dut.pending_q,      32'h0000_0080);

        // Backpressure: hold add x7 while addi x8,x0,5 waits
        bus.ready_in = 1'b0;
        issue(32'h0050_0413, 32'h108);
        #1 check("bp_ready", 32'(bus.instr_ready_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp%0d_valid", i), 32'(bus.valid_out),       32'h1);
            check($sformatf("bp%0d_rd", i),    32'(bus.rd_out),          32'd7);
            check($sformatf("bp%0d_pc", i),    bus.pc_co_out,            32'h104);
            check($sformatf("bp%0d_rs1", i),   bus.rs1_value_out,        32'h0000_000F);
            check($sformatf("bp%0d_ready", i), 32'(bus.instr_ready_out), 32'h0);
        end
        bus.ready_in = 1'b1;
        #1 check("bp_release_ready", 32'(bus.instr_ready_out), 32'h1);
        tick();
        bus.instr_valid_in = 1'b0;
        check("bp_next_valid", 32'(bus.valid_out), 32'h1);
        check("bp_next_rd",    32'(bus.rd_out),    32'd8);
        check("bp_next_imm",   bus.imm_value_out,  32'h5);
        check("bp_next_pc",    bus.pc_co_out,      32'h108);
        tick();
        check("bp_drained", 32'(bus.valid_out), 32'h0);

        // Flush a held addi x9 while writeback retires x7
        bus.ready_in = 1'b0;
        issue(32'h0030_0493, 32'h10C);
        tick();
        check("fl_held_rd",  32'(bus.rd_out), 32'd9);
        check("fl_pending0", dut.pending_q,   32'h0000_0380);
        bus.flush_in = 1'b1;
        wb(1'b1, 5'd7, 32'h0000_0077);
        issue(32'h0094_8533, 32'h110);
        #1 check("fl_ready", 32'(bus.instr_ready_out), 32'h0);
        tick();
        bus.flush_in = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        check("fl_valid",   32'(bus.valid_out), 32'h0);
        check("fl_pending", dut.pending_q,      32'h0000_0100);
        bus.ready_in = 1'b1;
        #1 check("fl_x9_ready", 32'(bus.instr_ready_out), 32'h1);
        tick();
        check("fl_x9_valid", 32'(bus.valid_out), 32'h1);
        check("fl_x9_rd",    32'(bus.rd_out),    32'd10);
        check("fl_x9_pc",    bus.pc_co_out,      32'h110);

        // sub x11,x5,x5
        issue(32'h4052_85B3, 32'h114);
        tick();
        check("sub_funct7", 32'(bus.funct7_out), 32'h20);
        check("sub_rs1",    bus.rs1_value_out,   32'h0000_0010);
        check("sub_rd",     32'(bus.rd_out),     32'd11);

        // sw x2,-4(x1)
        issue(32'hFE20_AE23, 32'h118);
        tick();
        check("sw_imm",    bus.imm_value_out,   32'hFFFF_FFFC);
        check("sw_rs1",    bus.rs1_value_out,   32'h0000_1000);
        check("sw_rs2",    bus.rs2_value_out,   32'h0000_CAFE);
        check("sw_rd",     32'(bus.rd_out),     32'd0);
        check("sw_funct7", 32'(bus.funct7_out), 32'h0);
        check("sw_funct3", 32'(bus.funct3_out), 32'h2);

        // beq x1,x2,-8
        issue(32'hFE20_8CE3, 32'h11C);
        tick();
        check("beq_imm",    bus.imm_value_out,   32'hFFFF_FFF8);
        check("beq_rd",     32'(bus.rd_out),     32'd0);
        check("beq_opcode", 32'(bus.opcode_out), 32'h63);

        // lui x1,0xABCDE
        issue(32'hABCD_E0B7, 32'h120);
        tick();
        check("lui_imm", bus.imm_value_out, 32'hABCD_E000);
        check("lui_rd",  32'(bus.rd_out),   32'd1);
        check("lui_rs1", bus.rs1_value_out, 32'h0);

        // opcode 0000000 with a nonzero rd field
        issue(32'h0000_0F80, 32'h124);
        tick();
        bus.instr_valid_in = 1'b0;
        check("ill_valid",   32'(bus.valid_out),   32'h1);
        check("ill_flag",    32'(bus.illegal_out), 32'h1);
        check("ill_rd",      32'(bus.rd_out),      32'd0);
        check("ill_imm",     bus.imm_value_out,    32'h0);
        check("ill_pending", dut.pending_q,        32'h0000_0D02);

        // Reset overrides flush, accept and writeback
        reset        = 1'b1;
        bus.flush_in = 1'b1;
        wb(1'b1, 5'd8, 32'h0000_0088);
        issue(32'h0050_0413, 32'h128);
        tick();
        reset        = 1'b0;
        bus.flush_in = 1'b0;
        bus.instr_valid_in = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        check("mrst_valid",   32'(bus.valid_out),   32'h0);
        check("mrst_pending", dut.pending_q,        32'h0);
        check("mrst_rd",      32'(bus.rd_out),      32'd0);
        check("mrst_pc",      bus.pc_co_out,        32'h0);
        check("mrst_illegal", 32'(bus.illegal_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
